fir_coef_bank_ctrl: RTL and testbench



---
 rtl/fir_ctrl_pkg.sv | 21 ++
 rtl/fir_coef_shadow_bank.sv | 62 ++++++
 rtl/fir_coef_bank_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_fir_coef_bank_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient bank controller.
// Contents: tap count, shadow write-index width, controller state encoding,
// and the reset passthrough value for b0.
package fir_ctrl_pkg;

  localparam int unsigned NUM_TAPS = 9;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2,
    ST_DRAIN   = 2'd3
  } ctrl_state_e;

  // 2^decimal_width - 1: the largest positive value, i.e. a ~1.0 gain tap.
  function automatic logic [31:0] passthrough_b0(input int unsigned decimal_width);
    return (32'd1 << decimal_width) - 32'd1;
  endfunction

endpackage

// File: rtl/fir_coef_shadow_bank.sv
// Shadow coefficient bank with sequential write index and atomic commit into
// the active bank.
// Ports:
//   aclk, resetn      clock, synchronous active-low reset
//   i_wr_en           write i_wr_data into the shadow bank this cycle
//   i_wr_first        this write starts a new set (index 0)
//   i_wr_data         coefficient word
//   i_commit          copy the whole shadow bank into the active bank
//   o_wr_idx          index the next (non-first) write will use
//   o_active          active coefficients, element 0 = b0
module fir_coef_shadow_bank
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned coefficient_width         = 16,
  parameter int unsigned coefficient_decimal_width = 15
) (
  input  logic                                        aclk,
  input  logic                                        resetn,
  input  logic                                        i_wr_en,
  input  logic                                        i_wr_first,
  input  logic [coefficient_width-1:0]                i_wr_data,
  input  logic                                        i_commit,
  output logic [CNT_W-1:0]                            o_wr_idx,
  output logic [NUM_TAPS-1:0][coefficient_width-1:0]  o_active
);

  localparam logic [coefficient_width-1:0] B0_RST =
    coefficient_width'(passthrough_b0(coefficient_decimal_width));

  logic [NUM_TAPS-1:0][coefficient_width-1:0] r_shadow;
  logic [NUM_TAPS-1:0][coefficient_width-1:0] r_active;
  logic [CNT_W-1:0]                           r_wr_idx;
  logic [CNT_W-1:0]                           w_idx;

  assign w_idx = i_wr_first ? '0 : r_wr_idx;

  // Shadow writes and commit transfer; active bank only moves on commit.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_shadow    <= '0;
      r_wr_idx    <= '0;
      r_active    <= '0;
      r_active[0] <= B0_RST;
    end else begin
      if (i_wr_en) begin
        for (int i = 0; i < int'(NUM_TAPS); i++) begin
          if (w_idx == CNT_W'(i)) begin
            r_shadow[i] <= i_wr_data;
          end
        end
        r_wr_idx <= w_idx + CNT_W'(1);
      end
      if (i_commit) begin
        r_active <= r_shadow;
      end
    end
  end

  assign o_wr_idx = r_wr_idx;
  assign o_active = r_active;

endmodule

// File: rtl/fir_coef_bank_ctrl.sv
// Coefficient controller for the 9-tap AXI-Stream FIR. Collects a coefficient
// set into a shadow bank and commits it to b0..b8 atomically on a FIR
// sample-accept edge (or after an idle timeout), so no output mixes tap sets.
// Ports:
//   aclk, resetn                  clock, synchronous active-low reset
//   s_coef_t{data,valid,last,ready}  coefficient stream, b0 first, tlast on b8
//   fir_tvalid, fir_tlast         copy of the FIR input handshake
//   b0..b8                        active coefficients (registered)
//   bank_pending                  complete set waiting for commit
//   swap_done                     pulse in the first cycle new taps are visible
//   load_error                    pulse after a malformed set
//   coef_version                  commit count, wraps
module fir_coef_bank_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned coefficient_width         = 16,
  parameter int unsigned coefficient_decimal_width = 15,
  parameter int unsigned swap_on_tlast             = 0,
  parameter int unsigned idle_swap_cycles          = 1024
) (
  input  logic                                aclk,
  input  logic                                resetn,
  input  logic [coefficient_width-1:0]        s_coef_tdata,
  input  logic                                s_coef_tvalid,
  input  logic                                s_coef_tlast,
  output logic                                s_coef_tready,
  input  logic                                fir_tvalid,
  input  logic                                fir_tlast,
  output logic signed [coefficient_width-1:0] b0,
  output logic signed [coefficient_width-1:0] b1,
  output logic signed [coefficient_width-1:0] b2,
  output logic signed [coefficient_width-1:0] b3,
  output logic signed [coefficient_width-1:0] b4,
  output logic signed [coefficient_width-1:0] b5,
  output logic signed [coefficient_width-1:0] b6,
  output logic signed [coefficient_width-1:0] b7,
  output logic signed [coefficient_width-1:0] b8,
  output logic                                bank_pending,
  output logic                                swap_done,
  output logic                                load_error,
  output logic [7:0]                          coef_version
);

  localparam int unsigned IDLE_W =
    (idle_swap_cycles > 1) ? $clog2(idle_swap_cycles + 1) : 1;

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;

  logic                                        r_tready;
  logic                                        r_pending;
  logic                                        r_swap_done;
  logic                                        r_load_error;
  logic [7:0]                                  r_coef_version;
  logic [IDLE_W-1:0]                           r_idle_cnt;

  logic                                        w_beat;
  logic                                        w_last_word;
  logic                                        w_fir_commit;
  logic                                        w_idle_commit;
  logic                                        w_commit_cond;
  logic                                        w_enter_pending;
  logic                                        w_wr_en;
  logic                                        w_wr_first;
  logic                                        w_load_err;
  logic                                        w_commit;
  logic [CNT_W-1:0]                            w_wr_idx;
  logic [NUM_TAPS-1:0][coefficient_width-1:0]  w_active;

  assign w_beat      = s_coef_tvalid && r_tready;
  assign w_last_word = (w_wr_idx == CNT_W'(NUM_TAPS - 1));

  // Sample-driven commit, optionally restricted to frame boundaries.
  assign w_fir_commit = fir_tvalid && ((swap_on_tlast == 0) || fir_tlast);

  // Forced commit on the edge that completes idle_swap_cycles sample-free
  // cycles in PENDING (the edge at which the idle counter reaches the limit).
  assign w_idle_commit = (idle_swap_cycles != 0) && !fir_tvalid &&
                         ((32'(r_idle_cnt) + 32'd1) == 32'(idle_swap_cycles));

  assign w_commit_cond   = w_fir_commit || w_idle_commit;
  assign w_enter_pending = (r_state != ST_PENDING) && (w_state_nxt == ST_PENDING);

  // State register.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_beat && !s_coef_tlast) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_beat) begin
          if (s_coef_tlast)     w_state_nxt = w_last_word ? ST_PENDING : ST_IDLE;
          else if (w_last_word) w_state_nxt = ST_DRAIN;
        end
      end
      ST_PENDING: begin
        if (w_commit_cond) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (w_beat && s_coef_tlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_first = 1'b0;
    w_load_err = 1'b0;
    w_commit   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_wr_en    = w_beat;
        w_wr_first = 1'b1;
        w_load_err = w_beat && s_coef_tlast;
      end
      ST_LOAD: begin
        w_wr_en    = w_beat;
        // Error when tlast and the ninth word do not coincide.
        w_load_err = w_beat && (s_coef_tlast != w_last_word);
      end
      ST_PENDING: begin
        w_commit = w_commit_cond;
      end
      default: ;
    endcase
  end

  // Registered status outputs; tready/pending follow the next state so they
  // are correct in the first cycle of that state.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_tready       <= 1'b0;
      r_pending      <= 1'b0;
      r_swap_done    <= 1'b0;
      r_load_error   <= 1'b0;
      r_coef_version <= 8'd0;
    end else begin
      r_tready     <= (w_state_nxt != ST_PENDING);
      r_pending    <= (w_state_nxt == ST_PENDING);
      r_swap_done  <= w_commit;
      r_load_error <= w_load_err;
      if (w_commit) begin
        r_coef_version <= r_coef_version + 8'd1;
      end
    end
  end

  // Idle counter: sample-free cycles spent in PENDING, saturating.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_idle_cnt <= '0;
    end else if (fir_tvalid || w_enter_pending) begin
      r_idle_cnt <= '0;
    end else if ((r_state == ST_PENDING) && (r_idle_cnt != IDLE_W'(idle_swap_cycles))) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  fir_coef_shadow_bank #(
    .coefficient_width         (coefficient_width),
    .coefficient_decimal_width (coefficient_decimal_width)
  ) u_shadow_bank (
    .aclk       (aclk),
    .resetn     (resetn),
    .i_wr_en    (w_wr_en),
    .i_wr_first (w_wr_first),
    .i_wr_data  (s_coef_tdata),
    .i_commit   (w_commit),
    .o_wr_idx   (w_wr_idx),
    .o_active   (w_active)
  );

  assign s_coef_tready = r_tready;
  assign bank_pending  = r_pending;
  assign swap_done     = r_swap_done;
  assign load_error    = r_load_error;
  assign coef_version  = r_coef_version;

  assign b0 = w_active[0];
  assign b1 = w_active[1];
  assign b2 = w_active[2];
  assign b3 = w_active[3];
  assign b4 = w_active[4];
  assign b5 = w_active[5];
  assign b6 = w_active[6];
  assign b7 = w_active[7];
  assign b8 = w_active[8];

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Directed bench for fir_coef_bank_ctrl. dut_a uses default parameters,
// dut_b commits only on FIR tlast and has a 16-cycle idle timeout. Stimulus is
// shared; sel routes the tvalid strobes to one instance at a time.
`timescale 1ns/1ps
module tb_fir_coef_bank_ctrl;

  typedef logic [8:0][15:0] bank_t;

  logic        aclk;
  logic        resetn;
  logic        sel;
  logic [15:0] coef_tdata;
  logic        coef_tvalid;
  logic        coef_tlast;
  logic        fir_tvalid;
  logic        fir_tlast;

  logic a_ctv, a_ftv, b_ctv, b_ftv;
  assign a_ctv = coef_tvalid & ~sel;
  assign a_ftv = fir_tvalid  & ~sel;
  assign b_ctv = coef_tvalid &  sel;
  assign b_ftv = fir_tvalid  &  sel;

  wire [8:0][15:0] a_b, b_b;
  logic a_tready, a_pending, a_swap, a_lerr;
  logic b_tready, b_pending, b_swap, b_lerr;
  logic [7:0] a_ver, b_ver;

  int n_checks = 0;
  int n_err    = 0;

  fir_coef_bank_ctrl dut_a (
    .aclk(aclk), .resetn(resetn),
    .s_coef_tdata(coef_tdata), .s_coef_tvalid(a_ctv), .s_coef_tlast(coef_tlast),
    .s_coef_tready(a_tready), .fir_tvalid(a_ftv), .fir_tlast(fir_tlast),
    .b0(a_b[0]), .b1(a_b[1]), .b2(a_b[2]), .b3(a_b[3]), .b4(a_b[4]),
    .b5(a_b[5]), .b6(a_b[6]), .b7(a_b[7]), .b8(a_b[8]),
    .bank_pending(a_pending), .swap_done(a_swap), .load_error(a_lerr),
    .coef_version(a_ver)
  );

  fir_coef_bank_ctrl #(
    .coefficient_width(16), .coefficient_decimal_width(15),
    .swap_on_tlast(1), .idle_swap_cycles(16)
  ) dut_b (
    .aclk(aclk), .resetn(resetn),
    .s_coef_tdata(coef_tdata), .s_coef_tvalid(b_ctv), .s_coef_tlast(coef_tlast),
    .s_coef_tready(b_tready), .fir_tvalid(b_ftv), .fir_tlast(fir_tlast),
    .b0(b_b[0]), .b1(b_b[1]), .b2(b_b[2]), .b3(b_b[3]), .b4(b_b[4]),
    .b5(b_b[5]), .b6(b_b[6]), .b7(b_b[7]), .b8(b_b[8]),
    .bank_pending(b_pending), .swap_done(b_swap), .load_error(b_lerr),
    .coef_version(b_ver)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bank(input string tag, input bank_t obs, input bank_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bank_t mk_bank(input logic [15:0] base, input logic [15:0] step);
    bank_t bk;
    for (int i = 0; i < 9; i++) bk[i] = base + 16'(i) * step;
    return bk;
  endfunction

  // Nine words b0..b8, tlast on the ninth; optionally a FIR sample on that beat.
  task automatic load_set(input bank_t bank, input bit fir_on_last);
    for (int i = 0; i < 9; i++) begin
      coef_tdata  = bank[i];
      coef_tvalid = 1'b1;
      coef_tlast  = (i == 8);
      fir_tvalid  = fir_on_last && (i == 8);
      tick();
    end
    coef_tvalid = 1'b0;
    coef_tlast  = 1'b0;
    fir_tvalid  = 1'b0;
  endtask

  initial begin
    bank_t bank_rst, set1, set3, setb1, setb2, exp_a;
    int errs;
    int bad;

    resetn = 1'b0; sel = 1'b0;
    coef_tdata = '0; coef_tvalid = 1'b0; coef_tlast = 1'b0;
    fir_tvalid = 1'b0; fir_tlast = 1'b0;
    bank_rst = '0;
    bank_rst[0] = 16'h7FFF;

    // Reset state
    repeat (3) tick();
    chk("tready_in_reset", a_tready, 0);
    resetn = 1'b1;
    tick();
    chk("rst_tready", a_tready, 1);
    chk_bank("rst_bank_a", a_b, bank_rst);
    chk_bank("rst_bank_b", b_b, bank_rst);
    chk("rst_version", a_ver, 0);
    chk("rst_pending", a_pending, 0);
    chk("rst_swap_done", a_swap, 0);
    chk("rst_load_error", a_lerr, 0);
    fir_tvalid = 1'b1;
    repeat (2) tick();
    fir_tvalid = 1'b0;
    chk_bank("idle_fir_no_change", a_b, bank_rst);
    chk("idle_fir_no_swap", a_swap, 0);

    // Valid set, sample three cycles after tlast commits it
    set1 = mk_bank(16'h0100, 16'h0100);
    load_set(set1, 1'b0);
    chk("pending_after_tlast", a_pending, 1);
    chk("tready_low_pending", a_tready, 0);
    chk_bank("bank_held_pending", a_b, bank_rst);
    tick(); tick();
    chk_bank("bank_held_no_sample", a_b, bank_rst);
    fir_tvalid = 1'b1;
    tick();
    fir_tvalid = 1'b0;
    chk_bank("commit_bank", a_b, set1);
    chk("commit_swap_done", a_swap, 1);
    chk("commit_version", a_ver, 1);
    chk("commit_pending_clr", a_pending, 0);
    chk("commit_tready", a_tready, 1);
    tick();
    chk("swap_done_single", a_swap, 0);
    chk_bank("commit_bank_hold", a_b, set1);

    // Early tlast on word 6
    for (int i = 0; i < 6; i++) begin
      coef_tdata = 16'hA000 + 16'(i); coef_tvalid = 1'b1; coef_tlast = (i == 5);
      tick();
    end
    coef_tvalid = 1'b0; coef_tlast = 1'b0;
    chk("short_set_error", a_lerr, 1);
    chk("short_set_no_pending", a_pending, 0);
    chk("short_set_tready", a_tready, 1);
    tick();
    chk("short_error_pulse", a_lerr, 0);
    chk_bank("short_bank_kept", a_b, set1);

    // Twelve words: error on word 9, rest drained
    errs = 0;
    for (int i = 0; i < 12; i++) begin
      coef_tdata = 16'hB000 + 16'(i); coef_tvalid = 1'b1; coef_tlast = (i == 11);
      tick();
      errs += int'(a_lerr);
      if (i == 8) chk("long_err_word9", a_lerr, 1);
      if (i == 10) chk("drain_tready", a_tready, 1);
    end
    coef_tvalid = 1'b0; coef_tlast = 1'b0;
    tick();
    errs += int'(a_lerr);
    chk("long_err_count", errs, 1);
    chk("long_no_pending", a_pending, 0);
    chk("long_tready_idle", a_tready, 1);
    chk_bank("long_bank_kept", a_b, set1);
    chk("long_version_kept", a_ver, 1);

    // Single beat with tlast
    coef_tdata = 16'hC000; coef_tvalid = 1'b1; coef_tlast = 1'b1;
    tick();
    coef_tvalid = 1'b0; coef_tlast = 1'b0;
    chk("one_word_error", a_lerr, 1);
    tick();

    // Sample on the tlast beat does not commit; next sample does
    set3 = mk_bank(16'h1000, 16'h0001);
    load_set(set3, 1'b1);
    chk("same_edge_pending", a_pending, 1);
    chk("same_edge_no_swap", a_swap, 0);
    chk_bank("same_edge_bank_old", a_b, set1);
    fir_tvalid = 1'b1;
    tick();
    fir_tvalid = 1'b0;
    chk_bank("first_edge_commit", a_b, set3);
    chk("first_edge_version", a_ver, 2);

    // dut_b: commit only on a FIR tlast sample
    sel = 1'b1;
    tick();
    setb1 = mk_bank(16'h2000, 16'h0001);
    load_set(setb1, 1'b0);
    chk("b_pending", b_pending, 1);
    for (int k = 1; k <= 5; k++) begin
      fir_tvalid = 1'b1; fir_tlast = (k == 5);
      tick();
      if (k < 5) chk_bank("b_no_commit_mid_frame", b_b, bank_rst);
    end
    fir_tvalid = 1'b0; fir_tlast = 1'b0;
    chk_bank("b_commit_on_tlast", b_b, setb1);
    chk("b_swap_done", b_swap, 1);
    chk("b_version", b_ver, 1);
    tick();

    // dut_b: idle timeout with no FIR traffic
    setb2 = mk_bank(16'h3000, 16'h0001);
    load_set(setb2, 1'b0);
    chk("b_idle_pending", b_pending, 1);
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16 && (b_tready !== 1'b0 || b_pending !== 1'b1 || b_b !== setb1)) bad++;
    end
    chk("b_idle_hold_cycles", bad, 0);
    chk_bank("b_idle_commit", b_b, setb2);
    chk("b_idle_swap_done", b_swap, 1);
    chk("b_idle_version", b_ver, 2);
    chk("b_idle_tready", b_tready, 1);

    // dut_a: version wraps after 256 commits
    sel = 1'b0;
    tick();
    exp_a = set3;
    for (int c = 2; c < 256; c++) begin
      exp_a = mk_bank(16'(c * 16), 16'h0001);
      load_set(exp_a, 1'b0);
      fir_tvalid = 1'b1;
      tick();
      fir_tvalid = 1'b0;
      if (c == 254) chk("version_255", a_ver, 255);
    end
    chk("version_wrap", a_ver, 0);
    chk_bank("wrap_bank", a_b, exp_a);

    // Reset while pending
    load_set(mk_bank(16'h5000, 16'h0001), 1'b0);
    chk("pre_reset_pending", a_pending, 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    chk_bank("reset_bank", a_b, bank_rst);
    chk("reset_pending", a_pending, 0);
    chk("reset_version", a_ver, 0);
    chk("reset_tready", a_tready, 1);
    chk("reset_version_b", b_ver, 0);
    fir_tvalid = 1'b1;
    tick();
    fir_tvalid = 1'b0;
    chk("reset_no_stale_swap", a_swap, 0);
    chk_bank("reset_no_stale_bank", a_b, bank_rst);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
